// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_23060042_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060042_lsu_align.sv
// Byte-lane steering: store mask/data replication and load extract/extend.
module ysyx_23060042_lsu_align
  import ysyx_23060042_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_off,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_sext,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic [4:0]  w_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_sh   = {i_ld_off, 3'b000};
  assign w_byte = 8'(i_rdata >> w_sh);
  assign w_half = 16'(i_rdata >> w_sh);

  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = 32'h0;
    case (i_st_size)
      SZ_B: begin
        o_wmask = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        o_wmask = 4'b0011 << i_st_off;
        o_wdata = {2{i_st_data[15:0]}};
      end
      SZ_W: begin
        o_wmask = 4'b1111;
        o_wdata = i_st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ldata = 32'h0;
    case (i_ld_size)
      SZ_B:    o_ldata = {{24{i_ld_sext & w_byte[7]}}, w_byte};
      SZ_H:    o_ldata = {{16{i_ld_sext & w_half[15]}}, w_half};
      SZ_W:    o_ldata = i_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_23060042_lsu.sv
// Load/store unit: one outstanding EXU access over a word-addressed memory bus.
module ysyx_23060042_lsu
  import ysyx_23060042_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_Mren,
  input  logic [1:0]  req_Mwen,
  input  logic        req_sext,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  lsu_state_t  r_state;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_mren;
  logic        r_sext;
  logic [CW-1:0] r_cnt;

  logic        w_nop;
  logic        w_bad;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_nop = (req_Mren == SZ_NONE) && (req_Mwen == SZ_NONE);
  assign w_bad = ((req_Mren != SZ_NONE) && (req_Mwen != SZ_NONE)) ||
                 misaligned(req_Mren | req_Mwen, req_addr[1:0]);

  // Store lanes come from the live request (registered at accept); loads use the latched request.
  ysyx_23060042_lsu_align u_align (
    .i_st_off  (req_addr[1:0]),
    .i_st_size (req_Mwen),
    .i_st_data (req_wdata),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata),
    .i_ld_off  (r_addr_lo),
    .i_ld_size (r_mren),
    .i_ld_sext (r_sext),
    .i_rdata   (mem_rdata),
    .o_ldata   (w_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr_lo <= 2'b00;
      r_mren    <= SZ_NONE;
      r_sext    <= 1'b0;
      r_cnt     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wen   <= 1'b0;
      mem_wmask <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr_lo <= req_addr[1:0];
            r_mren    <= req_Mren;
            r_sext    <= req_sext;
            req_ready <= 1'b0;
            if (w_nop || w_bad) begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= w_bad;
              rsp_rdata <= 32'h0;
            end else begin
              r_state   <= ISSUE;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wen   <= (req_Mwen != SZ_NONE);
              mem_wmask <= w_wmask;
              mem_wdata <= w_wdata;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          // A response on the final allowed cycle still beats the timeout.
          if (mem_rvalid) begin
            r_state   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_wen ? 32'h0 : w_ldata;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          r_cnt     <= '0;
          req_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
